// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the three buses around the memory arbiter:
//   icache side : iREN, iaddr  -> arbiter ; iwait, iload -> icache
//   dcache side : dREN, dWEN, daddr, dstore -> arbiter ; dwait, dload -> dcache
//   RAM side    : ramREN, ramWEN, ramaddr, ramstore, ram_err -> RAM/monitor
//                 ramload, ramstate -> arbiter
// Modports:
//   slave  : the arbiter's view
//   master : the view of the caches and RAM surrounding the arbiter
// ---------------------------------------------------------------------------
interface memory_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Arbitrates icache and dcache memory requests onto one single-ported RAM.
// Data requests win arbitration unless the instruction side has watched
// ISTARVE consecutive data transfers complete while it was waiting, in which
// case the instruction fetch is granted next.
// Ports:
//   CLK   : rising-edge clock
//   nRST  : asynchronous active-low reset
//   bus   : memory_arbiter_if.slave (cache request/response + RAM strobes)
// All RAM strobes and waits are decoded combinationally from the registered
// FSM state, so a wait can fall in the same cycle the RAM reports ACCESS.
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int WORD_W  = 32,
  parameter int ISTARVE = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  memory_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(ISTARVE + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(ISTARVE);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
  localparam logic [WORD_W-1:0]   WORD_ZERO   = {WORD_W{1'b0}};

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic              dreq_s;
  logic              iwait_s;
  logic              dwait_s;
  logic              ram_ren_s;
  logic              ram_wen_s;
  logic [WORD_W-1:0] ram_addr_s;
  logic [WORD_W-1:0] ram_store_s;
  logic              ram_err_s;

  assign dreq_s = bus.dREN | bus.dWEN;

  // State and starvation-streak registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= STREAK_ZERO;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Arbitration, grant progress, RAM strobe decode and streak update.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    iwait_s     = 1'b1;
    dwait_s     = 1'b1;
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ram_addr_s  = WORD_ZERO;
    ram_store_s = WORD_ZERO;
    ram_err_s   = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins unless the fetch has already been passed over ISTARVE times.
        if (dreq_s && (!bus.iREN || (streak_q < STREAK_MAX))) begin
          state_d = DGNT;
        end else if (bus.iREN) begin
          state_d = IGNT;
        end else begin
          state_d = IDLE;
        end
      end

      IGNT: begin
        ram_ren_s  = bus.iREN;
        ram_addr_s = bus.iaddr;
        if (!bus.iREN) begin
          // Request withdrawn: nothing completes, go re-arbitrate.
          state_d = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          iwait_s  = 1'b0;
          streak_d = STREAK_ZERO;
          state_d  = IDLE;
        end else begin
          state_d = IGNT;
        end
        if (bus.ramstate == RAM_ERROR) begin
          ram_err_s = 1'b1;
        end else begin
          ram_err_s = 1'b0;
        end
      end

      DGNT: begin
        // A simultaneous read+write request is carried out as a write.
        ram_wen_s   = bus.dWEN;
        ram_ren_s   = bus.dREN & ~bus.dWEN;
        ram_addr_s  = bus.daddr;
        ram_store_s = bus.dstore;
        if (!dreq_s) begin
          state_d = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          dwait_s = 1'b0;
          state_d = IDLE;
          if (bus.iREN) begin
            if (streak_q < STREAK_MAX) begin
              streak_d = streak_q + STREAK_ONE;
            end else begin
              streak_d = streak_q;
            end
          end else begin
            streak_d = STREAK_ZERO;
          end
        end else begin
          state_d = DGNT;
        end
        if (bus.ramstate == RAM_ERROR) begin
          ram_err_s = 1'b1;
        end else begin
          ram_err_s = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        streak_d = STREAK_ZERO;
      end
    endcase
  end

  assign bus.iwait    = iwait_s;
  assign bus.dwait    = dwait_s;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;
  assign bus.ram_err  = ram_err_s;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
// Drives icache/dcache request agents and a behavioural RAM around the
// arbiter. Each issued transfer pushes its expected result into a per-side
// queue; an independent monitor pops and compares whenever a wait falls.
// Expected data comes from a reference memory map (D writes applied in
// program order over a fixed hash pattern), kept apart from the RAM model.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int WORD_W  = 32;
  localparam int ISTARVE = 4;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK;
  logic nRST;

  memory_arbiter_if #(.WORD_W(WORD_W)) bus ();

  memory_arbiter #(.WORD_W(WORD_W), .ISTARVE(ISTARVE)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  exp_t iq[$];
  exp_t dq[$];
  byte  grant_log[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ram_mem [logic [31:0]];

  int ram_lat  = -1;  // -1: random latency per transfer
  int ram_wait = -1;  // -1: random non-ACCESS state while waiting
  int ram_cnt  = 0;
  int err_cnt  = 0;
  int dstreak  = 0;
  bit prev_comp = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reset-pattern content for every word that has never been written.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return rom(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM: counts down a latency while strobed, then gives ACCESS.
  always @(posedge CLK) begin
    #2;
    if (bus.ramREN || bus.ramWEN) begin
      if (ram_cnt == 0) begin
        bus.ramstate = 2'd2;
        if (bus.ramWEN) begin
          ram_mem[bus.ramaddr] = bus.ramstore;
          bus.ramload = $urandom;
        end else if (ram_mem.exists(bus.ramaddr)) begin
          bus.ramload = ram_mem[bus.ramaddr];
        end else begin
          bus.ramload = rom(bus.ramaddr);
        end
      end else begin
        int r;
        ram_cnt--;
        r = $urandom_range(2, 0);
        if (ram_wait >= 0) bus.ramstate = ram_wait[1:0];
        else if (r == 2) bus.ramstate = 2'd3;
        else bus.ramstate = r[1:0];
        bus.ramload = $urandom;
      end
    end else begin
      bus.ramstate = 2'd0;
      bus.ramload  = $urandom;
      ram_cnt = (ram_lat >= 0) ? ram_lat : int'($urandom_range(3, 0));
    end
  end

  // Monitor: compares every completion against the scoreboard queues.
  always @(negedge CLK) begin
    if (nRST) begin
      bit comp;
      comp = 1'b0;
      check("iload_pass", bus.iload, bus.ramload);
      check("dload_pass", bus.dload, bus.ramload);
      check("ram_err", 32'(bus.ram_err),
            32'((bus.ramREN || bus.ramWEN) && (bus.ramstate == 2'd3)));
      if (bus.ram_err) err_cnt++;
      if (prev_comp) begin
        check("bubble_ren", 32'(bus.ramREN), 32'd0);
        check("bubble_wen", 32'(bus.ramWEN), 32'd0);
      end
      if (!bus.iwait && !bus.dwait) check("both_wait_low", 32'd1, 32'd0);
      if (!bus.iwait) begin
        comp = 1'b1;
        grant_log.push_back("I");
        dstreak = 0;
        if (iq.size() == 0) begin
          check("i_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = iq.pop_front();
          check("i_state", 32'(bus.ramstate), 32'd2);
          check("i_ren", 32'(bus.ramREN), 32'd1);
          check("i_addr", bus.ramaddr, e.addr);
          check("i_data", bus.iload, e.data);
        end
      end
      if (!bus.dwait) begin
        comp = 1'b1;
        grant_log.push_back("D");
        if (bus.iREN) begin
          dstreak++;
          check("starve_bound", 32'(dstreak <= ISTARVE), 32'd1);
        end else begin
          dstreak = 0;
        end
        if (dq.size() == 0) begin
          check("d_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = dq.pop_front();
          check("d_state", 32'(bus.ramstate), 32'd2);
          check("d_wen", 32'(bus.ramWEN), 32'(e.wr));
          check("d_ren", 32'(bus.ramREN), 32'(!e.wr));
          check("d_addr", bus.ramaddr, e.addr);
          if (e.wr) check("d_store", bus.ramstore, e.data);
          else check("d_data", bus.dload, e.data);
        end
      end
      prev_comp = comp;
    end else begin
      prev_comp = 1'b0;
      dstreak   = 0;
    end
  end

  task automatic wait_done(input bit is_i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (is_i ? !bus.iwait : !bus.dwait) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(is_i ? "i_timeout" : "d_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic i_xfer(input logic [31:0] addr);
    exp_t e;
    bus.iaddr = addr;
    bus.iREN  = 1'b1;
    e.wr = 1'b0; e.addr = addr; e.data = ref_rd(addr);
    iq.push_back(e);
    wait_done(1'b1);
  endtask

  task automatic d_xfer(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] data);
    exp_t e;
    bus.daddr  = addr;
    bus.dstore = data;
    bus.dWEN   = wr;
    bus.dREN   = wr ? both : 1'b1;
    e.wr = wr; e.addr = addr;
    if (wr) begin
      ref_mem[addr] = data;
      e.data = data;
    end else begin
      e.data = ref_rd(addr);
    end
    dq.push_back(e);
    wait_done(1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [31:0] log_code();
    logic [31:0] c;
    c = 32'd0;
    foreach (grant_log[k]) c = {c[30:0], (grant_log[k] == "I")};
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_iwait", 32'(bus.iwait), 32'd1);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_ren", 32'(bus.ramREN), 32'd0);
    check("rst_wen", 32'(bus.ramWEN), 32'd0);
    check("rst_addr", bus.ramaddr, 32'd0);
    check("rst_store", bus.ramstore, 32'd0);
    check("rst_err", 32'(bus.ram_err), 32'd0);
    check("rst_streak", 32'(dut.streak_q), 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Single fetch, ACCESS two cycles after the strobe
    ram_lat = 2; ram_wait = 1;
    begin
      exp_t e;
      bus.iaddr = 32'h40; bus.iREN = 1'b1;
      e.wr = 1'b0; e.addr = 32'h40; e.data = ref_rd(32'h40);
      iq.push_back(e);
    end
    @(negedge CLK);
    check("t1_c0_ren", 32'(bus.ramREN), 32'd0);
    check("t1_c0_iwait", 32'(bus.iwait), 32'd1);
    @(negedge CLK);
    check("t1_c1_ren", 32'(bus.ramREN), 32'd1);
    check("t1_c1_addr", bus.ramaddr, 32'h40);
    check("t1_c1_iwait", 32'(bus.iwait), 32'd1);
    @(negedge CLK);
    check("t1_c2_iwait", 32'(bus.iwait), 32'd1);
    @(negedge CLK);
    check("t1_c3_iwait", 32'(bus.iwait), 32'd0);
    check("t1_c3_iload", bus.iload, rom(32'h40));
    @(posedge CLK); #1;
    bus.iREN = 1'b0;
    @(negedge CLK);
    check("t1_c4_iwait", 32'(bus.iwait), 32'd1);
    check("t1_c4_ren", 32'(bus.ramREN), 32'd0);
    ram_lat = -1; ram_wait = -1;
    idle_cycles(2);

    // Simultaneous I and D with streak 0: D first, then I
    grant_log.delete();
    fork
      begin i_xfer(32'h1010); bus.iREN = 1'b0; end
      begin d_xfer(1'b0, 1'b0, 32'h810, 32'd0); bus.dREN = 1'b0; end
    join
    idle_cycles(2);
    check("t2_count", grant_log.size(), 32'd2);
    check("t2_order", log_code(), 32'h1);

    // Starvation: five held writes against a held fetch -> D,D,D,D,I,D
    grant_log.delete();
    fork
      begin i_xfer(32'h1040); bus.iREN = 1'b0; end
      begin
        for (int k = 0; k < 5; k++) d_xfer(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
        bus.dWEN = 1'b0;
      end
    join
    idle_cycles(2);
    check("t3_count", grant_log.size(), 32'd6);
    check("t3_order", log_code(), 32'h2);
    check("t3_streak", 32'(dut.streak_q), 32'd0);

    // dREN & dWEN together are a write
    d_xfer(1'b1, 1'b1, 32'h80, 32'h0BADF00D);
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
    d_xfer(1'b0, 1'b0, 32'h80, 32'd0);
    bus.dREN = 1'b0;
    idle_cycles(2);

    // ERROR for three cycles, then ACCESS
    ram_lat = 3; ram_wait = 3;
    e0 = err_cnt;
    i_xfer(32'h1080);
    bus.iREN = 1'b0;
    ram_lat = -1; ram_wait = -1;
    idle_cycles(2);
    check("t5_err_cycles", err_cnt - e0, 32'd3);

    // Randomised concurrent traffic
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          idle_cycles($urandom_range(3, 0));
          i_xfer(32'h1000 | ($urandom & 32'hFFC));
          bus.iREN = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          int op;
          idle_cycles($urandom_range(3, 0));
          op = $urandom_range(2, 0);
          d_xfer(op != 0, op == 2, 32'h800 | ($urandom & 32'hFC), $urandom);
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
      end
    join
    idle_cycles(3);
    check("iq_drained", iq.size(), 32'd0);
    check("dq_drained", dq.size(), 32'd0);

    // Reset while a write is stuck in BUSY
    bus.iaddr = 32'h1100; bus.iREN = 1'b1;
    d_xfer(1'b1, 1'b0, 32'h840, 32'h12345678);
    ram_lat = 1000; ram_wait = 1;
    bus.daddr = 32'h200; bus.dstore = 32'hCAFEF00D; bus.dWEN = 1'b1; bus.dREN = 1'b0;
    repeat (3) @(negedge CLK);
    check("t6_pre_wen", 32'(bus.ramWEN), 32'd1);
    check("t6_pre_addr", bus.ramaddr, 32'h200);
    check("t6_pre_streak", 32'(dut.streak_q), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("t6_wen", 32'(bus.ramWEN), 32'd0);
    check("t6_ren", 32'(bus.ramREN), 32'd0);
    check("t6_iwait", 32'(bus.iwait), 32'd1);
    check("t6_dwait", 32'(bus.dwait), 32'd1);
    check("t6_streak", 32'(dut.streak_q), 32'd0);
    bus.iREN = 1'b0; bus.dWEN = 1'b0;
    ram_lat = -1; ram_wait = -1;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    check("t6_post_ren", 32'(bus.ramREN), 32'd0);
    check("t6_post_wen", 32'(bus.ramWEN), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
